fetch_sequencer: RTL and testbench

Controller that sequences the instruction-fetch stage. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents fetched words to decode through an IF/ID register with stall hold. It applies branch redirects from decode, with flush and discard of in-flight fetches. It detects HALT (opcode[31:21] all ones) or a fetch-count limit, then runs a fixed drain period before asserting done.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_sequencer_timer.sv | 36 +++
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the fetch sequencer
// Contents: state encoding, halt opcode, instruction size, halt-detect function.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } fetch_state_t;

  localparam logic [10:0] HALT_OPCODE = 11'h7FF;
  localparam logic [63:0] INSTR_BYTES = 64'd4;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:21] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_sequencer_timer.sv
// rtl/fetch_sequencer_timer.sv - halt_drain_timer: loadable down-counter with sticky done flag
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_load     load CYCLES and clear the done flag
//   i_en       count down by one (stops at zero)
//   o_done     set on the step that reaches zero; held until the next load or reset
module halt_drain_timer #(
  parameter int unsigned CYCLES = 5,
  parameter int unsigned W      = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  logic [W-1:0] r_cnt;
  logic         r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= W'(CYCLES);
      r_done <= 1'b0;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
      if (r_cnt == W'(1)) r_done <= 1'b1;
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer with IF/ID register, redirect and halt drain
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    leave IDLE (sampled in IDLE only)
//   imem_req/addr/ack/rdata  instruction memory handshake; req held until ack
//   stall                    decode cannot accept, hold IF/ID
//   pc_src, branch_addr      branch redirect from decode
//   if_valid/instr/pc        IF/ID register
//   halted, done             halt detected / drain finished (sticky)
//   fetch_count              accepted fetches, saturating
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned MAX_FETCH    = 21,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [63:0] branch_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        halted,
  output logic        done,
  output logic [31:0] fetch_count
);

  fetch_state_t r_state, w_state_next;
  logic [63:0]  r_pc, w_pc_next;
  logic [63:0]  r_addr;
  logic         r_kill, w_kill_next;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [63:0]  r_if_pc;
  logic         r_halted;
  logic [31:0]  r_fetch_count;
  logic [31:0]  w_count_inc;
  logic         w_load_addr, w_accept, w_halt_hit, w_clear_valid;
  logic         w_timer_done;

  assign w_count_inc = (r_fetch_count == 32'hFFFF_FFFF) ? r_fetch_count : r_fetch_count + 32'd1;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_kill_next   = r_kill;
    w_load_addr   = 1'b0;
    w_accept      = 1'b0;
    w_halt_hit    = 1'b0;
    w_clear_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_FETCH;
          w_load_addr  = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!imem_ack) begin
          // Redirect while waiting: the request cannot be aborted, so remember
          // to drop its data and park the new target in the PC.
          if (pc_src) begin
            w_kill_next = 1'b1;
            w_pc_next   = branch_addr;
          end
        end else if (!r_kill && !pc_src) begin
          w_accept  = 1'b1;
          w_pc_next = r_pc + INSTR_BYTES;
          if (is_halt(imem_rdata) || (w_count_inc == MAX_FETCH)) begin
            w_halt_hit   = 1'b1;
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_ISSUE;
          end
        end else begin
          // Stale data: discard and reissue at the (possibly just updated) PC.
          w_kill_next = 1'b0;
          if (pc_src) w_pc_next = branch_addr;
          w_load_addr = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (pc_src) begin
          w_clear_valid = 1'b1;
          w_pc_next     = branch_addr;
          w_state_next  = ST_FETCH;
          w_load_addr   = 1'b1;
        end else if (!stall) begin
          w_clear_valid = 1'b1;
          w_state_next  = ST_FETCH;
          w_load_addr   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!stall) w_clear_valid = 1'b1;
        if (w_timer_done) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!stall) w_clear_valid = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_addr        <= '0;
      r_kill        <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_kill  <= w_kill_next;
      if (w_load_addr) r_addr <= w_pc_next;
      if (w_accept) begin
        r_if_valid    <= 1'b1;
        r_if_instr    <= imem_rdata;
        r_if_pc       <= r_pc;
        r_fetch_count <= w_count_inc;
      end else if (w_clear_valid) begin
        r_if_valid <= 1'b0;
      end
      if (w_halt_hit) r_halted <= 1'b1;
    end
  end

  halt_drain_timer #(.CYCLES(DRAIN_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_halt_hit),
    .i_en   (r_state == ST_DRAIN),
    .o_done (w_timer_done)
  );

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_addr;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign halted      = r_halted;
  assign done        = w_timer_done;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [63:0] branch_addr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic        done;
  logic [31:0] fetch_count;

  fetch_sequencer #(.RESET_PC(64'h0), .MAX_FETCH(21), .DRAIN_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .branch_addr(branch_addr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .done(done), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          delay;     // extra wait cycles before ack
    int          redir;     // pc_src pulse at wait index; delay+1 = same cycle as ack; -1 none
    logic [63:0] branch;
    bit          discard;
    int          stall_n;
    bit          issue_br;  // redirect from ISSUE (asserted together with stall)
    logic [63:0] issue_tgt;
    int          exp_count;
    bit          exp_halt;
  } rec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_req_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic run_rec(input rec_t r);
    int   n;
    exp_t e;
    n = 0;
    while (!imem_req && n < 20) begin
      step;
      n++;
    end
    chk("req_seen", imem_req, 1'b1);
    if (!imem_req) return;
    last_req_cyc = cyc;
    chk("req_addr", imem_addr, r.addr);
    for (int w = 0; w <= r.delay; w++) begin
      pc_src      = (w == r.redir);
      branch_addr = r.branch;
      step;
      pc_src = 1'b0;
      chk("req_hold", {imem_req, imem_addr}, {1'b1, r.addr});
    end
    imem_ack    = 1'b1;
    imem_rdata  = r.data;
    pc_src      = (r.redir == r.delay + 1);
    branch_addr = r.branch;
    if (!r.discard) sb.push_back('{pc: r.addr, instr: r.data});
    step;
    imem_ack = 1'b0;
    pc_src   = 1'b0;
    chk("fetch_count", fetch_count, 32'(r.exp_count));
    chk("halted", halted, r.exp_halt);
    if (r.discard) begin
      chk("discard_valid", if_valid, 1'b0);
      chk("reissue_req", imem_req, 1'b1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    chk("if_valid", if_valid, 1'b1);
    chk("if_pc", if_pc, e.pc);
    chk("if_instr", if_instr, e.instr);
    chk("req_drop", imem_req, 1'b0);
    if (r.stall_n > 0) stall = 1'b1;
    for (int s = 0; s < r.stall_n; s++) begin
      step;
      chk("stall_hold", {if_valid, if_pc, if_instr, imem_req}, {1'b1, e.pc, e.instr, 1'b0});
    end
    if (r.issue_br) begin
      pc_src      = 1'b1;
      branch_addr = r.issue_tgt;
      step;
      pc_src = 1'b0;
      stall  = 1'b0;
      chk("issue_redirect", {if_valid, imem_req, imem_addr}, {1'b0, 1'b1, r.issue_tgt});
    end else begin
      stall = 1'b0;
    end
  endtask

  task automatic do_reset_start;
    rst = 1'b1;
    step;
    rst = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  rec_t tbl[6];
  rec_t r;
  int   t0;

  initial begin
    tbl[0] = '{64'h00, 32'h8B020020, 0, -1, 64'h0,  1'b0, 0, 1'b0, 64'h0, 1, 1'b0};
    tbl[1] = '{64'h04, 32'h91000421, 0, -1, 64'h0,  1'b0, 4, 1'b0, 64'h0, 2, 1'b0};
    tbl[2] = '{64'h08, 32'hDEADBEEF, 3,  1, 64'h40, 1'b1, 0, 1'b0, 64'h0, 2, 1'b0};
    tbl[3] = '{64'h40, 32'hCAFEF00D, 0,  1, 64'h80, 1'b1, 0, 1'b0, 64'h0, 2, 1'b0};
    tbl[4] = '{64'h80, 32'h12345678, 1, -1, 64'h0,  1'b0, 2, 1'b1, 64'h8, 3, 1'b0};
    tbl[5] = '{64'h08, 32'hFFE00000, 0, -1, 64'h0,  1'b0, 0, 1'b0, 64'h0, 4, 1'b1};

    step;
    step;
    chk("reset_outputs", {imem_req, imem_addr, if_valid, if_instr, if_pc, halted, done, fetch_count},
        {1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0});
    rst = 1'b0;
    step;
    chk("idle_no_req", imem_req, 1'b0);
    start = 1'b1;
    step;
    start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_rec(tbl[i]);
      if (i == 0) t0 = last_req_cyc;
      if (i == 1) chk("throughput", 64'(last_req_cyc - t0), 64'd3);
    end

    // Drain after HALT: stall keeps the halt word, start/pc_src ignored.
    stall = 1'b1;
    start = 1'b1;
    pc_src = 1'b1;
    branch_addr = 64'h100;
    for (int k = 1; k <= 5; k++) begin
      step;
      chk("drain_done", done, (k == 5));
      chk("drain_no_req", imem_req, 1'b0);
      if (k == 1) begin
        chk("drain_hold_valid", if_valid, 1'b1);
        stall = 1'b0;
      end
      if (k == 2) chk("drain_clear_valid", if_valid, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step;
      chk("done_sticky", {done, halted, imem_req}, {1'b1, 1'b1, 1'b0});
    end
    start = 1'b0;
    pc_src = 1'b0;

    // Fetch-count limit on a non-halting stream.
    do_reset_start();
    chk("restart_addr", {imem_req, imem_addr, fetch_count}, {1'b1, 64'h0, 32'h0});
    for (int i = 0; i < 21; i++) begin
      r = '{64'(4 * i), 32'h00000013, 0, -1, 64'h0, 1'b0, 0, 1'b0, 64'h0, i + 1, (i == 20)};
      run_rec(r);
    end
    step;
    chk("limit_no_req", imem_req, 1'b0);

    // Asynchronous reset in the middle of a request.
    do_reset_start();
    for (int i = 0; i < 4; i++) begin
      r = '{64'(4 * i), 32'h00000013, 0, -1, 64'h0, 1'b0, 0, 1'b0, 64'h0, i + 1, 1'b0};
      run_rec(r);
    end
    step;
    chk("mid_req", {imem_req, imem_addr}, {1'b1, 64'h10});
    rst = 1'b1;
    #1;
    chk("async_reset", {imem_req, imem_addr, if_valid, if_pc, halted, done, fetch_count},
        {1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0});
    step;
    rst = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("reset_pc", {imem_req, imem_addr}, {1'b1, 64'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
